// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_loader
//  Description : Program loader for the Simple RISC Machine. Packs one
//                assembly-level instruction per handshake into the 16-bit
//                machine format and writes it to instruction RAM at
//                consecutive addresses, stopping on HALT or on the last word.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        opcode,
   input  logic [1:0]        op,
   input  logic [2:0]        rn,
   input  logic [2:0]        rd,
   input  logic [2:0]        rm,
   input  logic [1:0]        shift,
   input  logic [7:0]        imm,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              full,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W-1:0] c_addr_max = '1;
   localparam logic [15:0]       c_halt_word = 16'hE000;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_FULL  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;       // next address to be written
   logic [ADDR_W-1:0] r_mem_addr;   // address of the word being / last written
   logic [15:0]       r_wdata;
   logic              r_is_halt;    // word held in r_wdata is HALT
   logic              r_err;
   logic [ADDR_W:0]   r_count;

   logic              w_xfer;
   logic              w_legal;
   logic              w_halt;
   logic [15:0]       w_word;
   logic              w_last;

   // A transfer needs the loader armed; a coincident start takes priority.
   assign w_xfer = in_valid && (r_state == S_ARMED) && !start;
   assign w_last = (r_mem_addr == c_addr_max);

   // Encode the instruction fields and classify them as legal / HALT.
   always_comb begin
      w_legal = 1'b0;
      w_halt  = 1'b0;
      w_word  = 16'h0000;
      case (opcode)
         3'b110: begin
            if (op == 2'b10) begin
               w_legal = 1'b1;
               w_word  = {3'b110, 2'b10, rn, imm};
            end else if (op == 2'b00) begin
               w_legal = 1'b1;
               w_word  = {3'b110, 2'b00, 3'b000, rd, shift, rm};
            end
         end
         3'b101: begin
            w_legal = 1'b1;
            w_word  = {3'b101, op, rn, rd, shift, rm};
         end
         3'b011, 3'b100: begin
            // Offset must fit a signed 5-bit field: upper bits are sign copies.
            if ((op == 2'b00) && (imm[7:5] == {3{imm[4]}})) begin
               w_legal = 1'b1;
               w_word  = {opcode, 2'b00, rn, rd, imm[4:0]};
            end
         end
         3'b111: begin
            if (op == 2'b00) begin
               w_legal = 1'b1;
               w_halt  = 1'b1;
               w_word  = c_halt_word;
            end
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; start re-arms from any state.
   always_comb begin
      w_next = r_state;
      if (start) begin
         w_next = S_ARMED;
      end else begin
         case (r_state)
            S_IDLE:  w_next = S_IDLE;
            S_ARMED: begin
               if (w_xfer && w_legal) begin
                  w_next = S_WRITE;
               end
            end
            S_WRITE: begin
               if (r_is_halt) begin
                  w_next = S_DONE;
               end else if (w_last) begin
                  w_next = S_FULL;
               end else begin
                  w_next = S_ARMED;
               end
            end
            S_DONE:  w_next = S_DONE;
            S_FULL:  w_next = S_FULL;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Write-port registers: captured on a legal transfer, held otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_addr <= '0;
         r_wdata    <= 16'h0000;
         r_is_halt  <= 1'b0;
      end else if (w_xfer && w_legal) begin
         r_mem_addr <= r_addr;
         r_wdata    <= w_word;
         r_is_halt  <= w_halt;
      end
   end

   // Address pointer, sticky error flag and word counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr  <= '0;
         r_err   <= 1'b0;
         r_count <= '0;
      end else if (start) begin
         r_addr  <= base_addr;
         r_err   <= 1'b0;
         r_count <= '0;
      end else begin
         if (w_xfer && !w_legal) begin
            r_err <= 1'b1;
         end
         if (r_state == S_WRITE) begin
            r_count <= r_count + 1'b1;
            // The pointer never wraps: it stays put after HALT or the last word.
            if (!r_is_halt && !w_last) begin
               r_addr <= r_addr + 1'b1;
            end
         end
      end
   end

   assign in_ready   = (r_state == S_ARMED);
   assign mem_write  = (r_state == S_WRITE);
   assign done       = (r_state == S_DONE);
   assign full       = (r_state == S_FULL);
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_wdata;
   assign err        = r_err;
   assign word_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder_loader
//  Description : Self-checking bench for instr_encoder_loader with an
//                arithmetic reference encoder and a small loader model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          in_valid = 1'b0;
   logic [2:0]    opcode = '0, rn = '0, rd = '0, rm = '0;
   logic [1:0]    op = '0, shift = '0;
   logic [7:0]    imm = '0;
   logic          in_ready, mem_write, full, done, err;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata;
   logic [AW:0]   word_count;

   // Second instance with a 4-word memory for the full/no-wrap scenario.
   logic          s_start = 1'b0;
   logic [1:0]    s_base = '0;
   logic          s_in_valid = 1'b0;
   logic          s_in_ready, s_mem_write, s_full, s_done, s_err;
   logic [1:0]    s_mem_addr;
   logic [15:0]   s_mem_wdata;
   logic [2:0]    s_word_count;

   instr_encoder_loader #(.ADDR_W(AW)) u_dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .op(op),
      .rn(rn), .rd(rd), .rm(rm), .shift(shift), .imm(imm),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .full(full), .done(done), .err(err), .word_count(word_count)
   );

   instr_encoder_loader #(.ADDR_W(2)) u_small (
      .clk(clk), .reset(reset), .start(s_start), .base_addr(s_base),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .opcode(opcode), .op(op),
      .rn(rn), .rd(rd), .rm(rm), .shift(shift), .imm(imm),
      .mem_write(s_mem_write), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .full(s_full), .done(s_done), .err(s_err), .word_count(s_word_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Loader model: next address, words since start, sticky error, stopped.
   int m_addr  = 0;
   int m_count = 0;
   bit m_err   = 1'b0;
   bit m_stop  = 1'b0;

   // Reference encoder built from field weights (bit position = power of 2).
   function automatic void model_enc(input int opc, input int p, input int n,
                                     input int d, input int m, input int s,
                                     input int i, output bit legal,
                                     output bit halt, output logic [15:0] w);
      int v;
      int si;
      legal = 1'b0;
      halt  = 1'b0;
      v     = 0;
      si    = (i >= 128) ? i - 256 : i;
      if (opc == 6 && p == 2) begin
         legal = 1'b1; v = 6 * 8192 + 2 * 2048 + n * 256 + i;
      end else if (opc == 6 && p == 0) begin
         legal = 1'b1; v = 6 * 8192 + d * 32 + s * 8 + m;
      end else if (opc == 5) begin
         legal = 1'b1; v = 5 * 8192 + p * 2048 + n * 256 + d * 32 + s * 8 + m;
      end else if ((opc == 3 || opc == 4) && p == 0 && si >= -16 && si <= 15) begin
         legal = 1'b1; v = opc * 8192 + n * 256 + d * 32 + (si & 31);
      end else if (opc == 7 && p == 0) begin
         legal = 1'b1; halt = 1'b1; v = 57344;
      end
      w = v[15:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input int opc, input int p, input int n, input int d,
                             input int m, input int s, input int i);
      opcode = opc[2:0]; op = p[1:0]; rn = n[2:0]; rd = d[2:0];
      rm = m[2:0]; shift = s[1:0]; imm = i[7:0];
   endtask

   task automatic do_start(input int base);
      start = 1'b1;
      base_addr = base[AW-1:0];
      tick();
      start = 1'b0;
      m_addr = base; m_count = 0; m_err = 1'b0; m_stop = 1'b0;
      checks++;
      if ({in_ready, err, done, full, mem_write} !== 5'b10000 || word_count !== 9'd0) begin
         errors++;
         $display("FAIL start: ready/err/done/full/wr=%b count=%0d, required 10000 count=0",
                  {in_ready, err, done, full, mem_write}, word_count);
      end
   endtask

   // One full instruction handshake, checked cycle by cycle against the model.
   task automatic send(input int opc, input int p, input int n, input int d,
                       input int m, input int s, input int i);
      bit          legal, halt;
      logic [15:0] w;
      model_enc(opc, p, n, d, m, s, i, legal, halt, w);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_ready: in_ready=%b, required 1", in_ready);
      end
      set_fields(opc, p, n, d, m, s, i);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (legal) begin
         checks++;
         if (mem_write !== 1'b1 || mem_addr !== m_addr[AW-1:0] || mem_wdata !== w || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL write: wr=%b addr=%h data=%h ready=%b, required 1 %h %h 0",
                     mem_write, mem_addr, mem_wdata, in_ready, m_addr[AW-1:0], w);
         end
         tick();
         m_count++;
         checks++;
         if (mem_write !== 1'b0 || word_count !== m_count[AW:0] || err !== m_err) begin
            errors++;
            $display("FAIL post_write: wr=%b count=%0d err=%b, required 0 %0d %b",
                     mem_write, word_count, err, m_count, m_err);
         end
         if (halt) begin
            m_stop = 1'b1;
            checks++;
            if (done !== 1'b1 || in_ready !== 1'b0 || full !== 1'b0) begin
               errors++;
               $display("FAIL halt_state: done=%b ready=%b full=%b, required 1 0 0", done, in_ready, full);
            end
         end else if (m_addr == (1 << AW) - 1) begin
            m_stop = 1'b1;
            checks++;
            if (full !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
               errors++;
               $display("FAIL full_state: full=%b ready=%b done=%b, required 1 0 0", full, in_ready, done);
            end
         end else begin
            m_addr++;
            checks++;
            if (in_ready !== 1'b1 || done !== 1'b0 || full !== 1'b0) begin
               errors++;
               $display("FAIL rearm: ready=%b done=%b full=%b, required 1 0 0", in_ready, done, full);
            end
         end
      end else begin
         m_err = 1'b1;
         checks++;
         if (mem_write !== 1'b0 || err !== 1'b1 || in_ready !== 1'b1 || word_count !== m_count[AW:0]) begin
            errors++;
            $display("FAIL illegal: wr=%b err=%b ready=%b count=%0d, required 0 1 1 %0d",
                     mem_write, err, in_ready, word_count, m_count);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++;
      if ({in_ready, mem_write, done, full, err, mem_addr, mem_wdata, word_count} !== '0 ||
          {s_in_ready, s_mem_write, s_done, s_full, s_err, s_mem_addr, s_mem_wdata, s_word_count} !== '0) begin
         errors++;
         $display("FAIL reset_values: ready=%b wr=%b addr=%h data=%h count=%0d, required all 0",
                  in_ready, mem_write, mem_addr, mem_wdata, word_count);
      end
      tick();
      reset = 1'b0;
      tick();
      set_fields(6, 2, 0, 0, 0, 0, 7);
      in_valid = 1'b1;
      tick();
      tick();
      checks++;
      if (mem_write !== 1'b0 || in_ready !== 1'b0 || word_count !== 9'd0) begin
         errors++;
         $display("FAIL idle_ignore: wr=%b ready=%b count=%0d, required 0 0 0", mem_write, in_ready, word_count);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_encode_basic();
      do_start(16);
      send(6, 2, 0, 0, 0, 0, 7);
      checks++;
      if (mem_wdata !== 16'hD007 || mem_addr !== 8'h10 || word_count !== 9'd1) begin
         errors++;
         $display("FAIL mov_imm: data=%h addr=%h count=%0d, required d007 10 1", mem_wdata, mem_addr, word_count);
      end
      send(5, 0, 1, 2, 0, 1, 0);
      checks++;
      if (mem_wdata !== 16'hA148 || mem_addr !== 8'h11) begin
         errors++;
         $display("FAIL add: data=%h addr=%h, required a148 11", mem_wdata, mem_addr);
      end
      send(3, 0, 2, 1, 0, 0, 8'hFF);
      checks++;
      if (mem_wdata !== 16'h623F || mem_addr !== 8'h12 || word_count !== 9'd3) begin
         errors++;
         $display("FAIL ldr: data=%h addr=%h count=%0d, required 623f 12 3", mem_wdata, mem_addr, word_count);
      end
   endtask

   task automatic test_illegal();
      send(3, 0, 2, 1, 0, 0, 8'h10);
      send(6, 1, 0, 0, 0, 0, 0);
      checks++;
      if (mem_wdata !== 16'h623F || word_count !== 9'd3 || err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_hold: data=%h count=%0d err=%b, required 623f 3 1", mem_wdata, word_count, err);
      end
      do_start(48);
   endtask

   task automatic test_halt();
      send(7, 0, 0, 0, 0, 0, 0);
      in_valid = 1'b1;
      set_fields(6, 2, 1, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (mem_write !== 1'b0 || done !== 1'b1 || in_ready !== 1'b0 || word_count !== 9'd1) begin
            errors++;
            $display("FAIL done_hold: wr=%b done=%b ready=%b count=%0d, required 0 1 0 1",
                     mem_write, done, in_ready, word_count);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_full();
      do_start(254);
      send(6, 2, 1, 0, 0, 0, 1);
      send(6, 2, 2, 0, 0, 0, 2);
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      checks++;
      if (mem_write !== 1'b0 || mem_addr !== 8'hFF || full !== 1'b1 || word_count !== 9'd2) begin
         errors++;
         $display("FAIL full_hold: wr=%b addr=%h full=%b count=%0d, required 0 ff 1 2",
                  mem_write, mem_addr, full, word_count);
      end
      s_start = 1'b1;
      s_base = 2'd3;
      tick();
      s_start = 1'b0;
      set_fields(6, 2, 1, 0, 0, 0, 1);
      s_in_valid = 1'b1;
      tick();
      s_in_valid = 1'b0;
      checks++;
      if (s_mem_write !== 1'b1 || s_mem_addr !== 2'd3 || s_mem_wdata !== 16'hD101) begin
         errors++;
         $display("FAIL small_write: wr=%b addr=%0d data=%h, required 1 3 d101", s_mem_write, s_mem_addr, s_mem_wdata);
      end
      tick();
      checks++;
      if (s_full !== 1'b1 || s_in_ready !== 1'b0 || s_word_count !== 3'd1) begin
         errors++;
         $display("FAIL small_full: full=%b ready=%b count=%0d, required 1 0 1", s_full, s_in_ready, s_word_count);
      end
      s_in_valid = 1'b1;
      tick();
      tick();
      s_in_valid = 1'b0;
      checks++;
      if (s_mem_write !== 1'b0 || s_mem_addr !== 2'd3 || s_word_count !== 3'd1) begin
         errors++;
         $display("FAIL small_nowrap: wr=%b addr=%0d count=%0d, required 0 3 1", s_mem_write, s_mem_addr, s_word_count);
      end
   endtask

   task automatic test_start_in_write();
      do_start(5);
      set_fields(6, 2, 2, 0, 0, 0, 8'h33);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      start = 1'b1;
      base_addr = 8'h20;
      checks++;
      if (mem_write !== 1'b1 || mem_addr !== 8'h05 || mem_wdata !== 16'hD233) begin
         errors++;
         $display("FAIL start_write_cur: wr=%b addr=%h data=%h, required 1 05 d233", mem_write, mem_addr, mem_wdata);
      end
      tick();
      start = 1'b0;
      m_addr = 32; m_count = 0; m_err = 1'b0; m_stop = 1'b0;
      checks++;
      if (mem_write !== 1'b0 || in_ready !== 1'b1 || word_count !== 9'd0 || mem_addr !== 8'h05) begin
         errors++;
         $display("FAIL start_write_after: wr=%b ready=%b count=%0d addr=%h, required 0 1 0 05",
                  mem_write, in_ready, word_count, mem_addr);
      end
      send(6, 2, 3, 0, 0, 0, 8'h44);
   endtask

   task automatic test_start_vs_valid();
      set_fields(5, 1, 1, 1, 1, 1, 0);
      in_valid = 1'b1;
      start = 1'b1;
      base_addr = 8'h40;
      tick();
      in_valid = 1'b0;
      start = 1'b0;
      m_addr = 64; m_count = 0; m_err = 1'b0; m_stop = 1'b0;
      tick();
      checks++;
      if (mem_write !== 1'b0 || in_ready !== 1'b1 || word_count !== 9'd0) begin
         errors++;
         $display("FAIL start_wins: wr=%b ready=%b count=%0d, required 0 1 0", mem_write, in_ready, word_count);
      end
      send(5, 3, 7, 6, 5, 2, 0);
   endtask

   task automatic test_reset_mid_write();
      set_fields(6, 0, 0, 3, 4, 2, 0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (mem_write !== 1'b0 || in_ready !== 1'b0 || word_count !== 9'd0 || mem_addr !== 8'h00) begin
         errors++;
         $display("FAIL reset_kill: wr=%b ready=%b count=%0d addr=%h, required 0 0 0 00",
                  mem_write, in_ready, word_count, mem_addr);
      end
      tick();
      reset = 1'b0;
      tick();
      do_start(0);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 60; k++) begin
         if (m_stop) do_start(int'($urandom_range(0, 250)));
         send(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 255)));
      end
   endtask

   initial begin
      test_reset();
      test_encode_basic();
      test_illegal();
      test_halt();
      test_full();
      test_start_in_write();
      test_start_vs_valid();
      test_reset_mid_write();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
